// File: rtl/framebuffer_scanout_pkg.sv
// framebuffer_scanout_pkg: 640x480@60 VGA geometry and the buffer-swap FSM state
// shared by the display-side scan-out path.
package framebuffer_scanout_pkg;
  localparam int CW      = 10;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  typedef enum logic {SW_IDLE, SW_PENDING} swap_state_e;
endpackage

// File: rtl/framebuffer_scanout_vga_timing.sv
// framebuffer_scanout_vga_timing: pixel-enable divider, hc/vc raster counters and
// the visible/sync decodes plus per-tick vblank-start and frame-start strobes.
module framebuffer_scanout_vga_timing
  import framebuffer_scanout_pkg::*;
#(
  parameter int HVIS  = H_VIS,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VVIS  = V_VIS,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          pix_en_o,
  output logic [CW-1:0] hc_o,
  output logic [CW-1:0] vc_o,
  output logic          visible_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          vblank_start_o,
  output logic          frame_start_o
);
  localparam logic [CW-1:0] HV  = CW'(HVIS);
  localparam logic [CW-1:0] VV  = CW'(VVIS);
  localparam logic [CW-1:0] HS0 = CW'(HVIS + HFP);
  localparam logic [CW-1:0] HS1 = CW'(HVIS + HFP + HSYNC);
  localparam logic [CW-1:0] VS0 = CW'(VVIS + VFP);
  localparam logic [CW-1:0] VS1 = CW'(VVIS + VFP + VSYNC);
  localparam logic [CW-1:0] HL  = CW'(HVIS + HFP + HSYNC + HBP - 1);
  localparam logic [CW-1:0] VL  = CW'(VVIS + VFP + VSYNC + VBP - 1);
  logic          pix_en_q;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  always_comb begin
    hc_d = (hc_q == HL) ? '0 : hc_q + 1'b1;
    vc_d = (hc_q != HL) ? vc_q : ((vc_q == VL) ? '0 : vc_q + 1'b1);
  end
  // Counters hold the pixel about to be issued; they step only on tick edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_en_q <= 1'b0;
      hc_q     <= '0;
      vc_q     <= '0;
    end else begin
      pix_en_q <= ~pix_en_q;
      if (pix_en_q) begin
        hc_q <= hc_d;
        vc_q <= vc_d;
      end
    end
  end
  assign pix_en_o       = pix_en_q;
  assign hc_o           = hc_q;
  assign vc_o           = vc_q;
  assign visible_o      = (hc_q < HV) && (vc_q < VV);
  assign hsync_o        = (hc_q >= HS0) && (hc_q < HS1);
  assign vsync_o        = (vc_q >= VS0) && (vc_q < VS1);
  assign vblank_start_o = pix_en_q && (hc_q == '0) && (vc_q == VV);
  assign frame_start_o  = pix_en_q && (hc_q == '0) && (vc_q == '0);
endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: reads the 1-bit framebuffer in raster order, maps bits to RGB
// on the VGA pins and swaps the displayed buffer only at the start of vblank.
module framebuffer_scanout
  import framebuffer_scanout_pkg::*;
#(
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  parameter int          HVIS     = H_VIS,
  parameter int          HFP      = H_FP,
  parameter int          HSYNC    = H_SYNC,
  parameter int          HBP      = H_BP,
  parameter int          VVIS     = V_VIS,
  parameter int          VFP      = V_FP,
  parameter int          VSYNC    = V_SYNC,
  parameter int          VBP      = V_BP
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          swap_req,
  input  logic          read_data,
  output logic [CW-1:0] ReadX,
  output logic [CW-1:0] ReadY,
  output logic          read_buf,
  output logic          swap_ack,
  output logic          frame_start,
  output logic          VGA_CLK,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N
);
  logic          tick, vis, hs, vs, vb_start, fs_strobe;
  logic [CW-1:0] hc, vc;
  logic [CW-1:0] read_x_q, read_y_q;
  logic          vis1_q, hs1_q, vs1_q;
  logic [23:0]   rgb_q;
  logic          hs2_q, vs2_q, blank_n_q, frame_start_q;
  swap_state_e   state_q;
  logic          read_buf_q, swap_ack_q, swap_go;

  framebuffer_scanout_vga_timing #(
    .HVIS(HVIS), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VVIS(VVIS), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP)
  ) u_vga_timing (
    .clk_i         (Clk),
    .rst_ni        (Reset_n),
    .pix_en_o      (tick),
    .hc_o          (hc),
    .vc_o          (vc),
    .visible_o     (vis),
    .hsync_o       (hs),
    .vsync_o       (vs),
    .vblank_start_o(vb_start),
    .frame_start_o (fs_strobe)
  );

  // Stage 1 issues the address; stage 2 colours the returned bit, syncs ride along.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_x_q      <= '0;
      read_y_q      <= '0;
      vis1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      rgb_q         <= '0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= fs_strobe;
      if (tick) begin
        read_x_q  <= vis ? hc : '0;
        read_y_q  <= vis ? vc : '0;
        vis1_q    <= vis;
        hs1_q     <= ~hs;
        vs1_q     <= ~vs;
        rgb_q     <= vis1_q ? (read_data ? FG_COLOR : BG_COLOR) : '0;
        hs2_q     <= hs1_q;
        vs2_q     <= vs1_q;
        blank_n_q <= vis1_q;
      end
    end
  end

  // A request coinciding with vblank start swaps immediately instead of waiting a frame.
  assign swap_go = vb_start && ((state_q == SW_PENDING) || swap_req);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= SW_IDLE;
      read_buf_q <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= swap_go;
      read_buf_q <= read_buf_q ^ swap_go;
      state_q    <= vb_start ? SW_IDLE : (swap_req ? SW_PENDING : state_q);
    end
  end

  assign ReadX       = read_x_q;
  assign ReadY       = read_y_q;
  assign read_buf    = read_buf_q;
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign VGA_CLK     = tick;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: full-size instance for line timing, shrunken-raster instance
// for whole frames and swaps, both checked against a raster-position reference model.
module tb_framebuffer_scanout;
  typedef struct packed {int hv; int hfp; int hs; int hbp; int vv; int vfp; int vs; int vbp;} geom_t;
  localparam geom_t GF = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geom_t GS = '{16, 2, 4, 3, 12, 2, 2, 3};
  localparam logic [23:0] SFG = 24'h12A5FE;
  localparam logic [23:0] SBG = 24'h3C0081;
  localparam int SFR = 475;
  localparam int SVB = 300;

  logic Clk = 1'b0, Reset_n = 1'b0, swap_req = 1'b0;
  always #10 Clk = ~Clk;

  logic fb [0:479][0:639];
  int vectors = 0, errors = 0, c;
  logic m_pend, m_rb, m_ack;

  logic [9:0] f_rx, f_ry, s_rx, s_ry;
  logic [7:0] f_r, f_g, f_b, s_r, s_g, s_b;
  logic f_rd, f_rb, f_ack, f_fs, f_clk, f_hs, f_vs, f_bn, f_sn;
  logic s_rd, s_rb, s_ack, s_fs, s_clk, s_hs, s_vs, s_bn, s_sn;
  logic [48:0] f_obs, s_obs;
  assign f_rd  = fb[f_ry][f_rx];
  assign s_rd  = fb[s_ry][s_rx];
  assign f_obs = {f_rx, f_ry, f_r, f_g, f_b, f_hs, f_vs, f_bn, f_fs, f_clk};
  assign s_obs = {s_rx, s_ry, s_r, s_g, s_b, s_hs, s_vs, s_bn, s_fs, s_clk};

  framebuffer_scanout dut_full (
    .Clk(Clk), .Reset_n(Reset_n), .swap_req(1'b0), .read_data(f_rd),
    .ReadX(f_rx), .ReadY(f_ry), .read_buf(f_rb), .swap_ack(f_ack), .frame_start(f_fs),
    .VGA_CLK(f_clk), .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_HS(f_hs), .VGA_VS(f_vs),
    .VGA_BLANK_N(f_bn), .VGA_SYNC_N(f_sn)
  );

  framebuffer_scanout #(
    .FG_COLOR(SFG), .BG_COLOR(SBG),
    .HVIS(16), .HFP(2), .HSYNC(4), .HBP(3), .VVIS(12), .VFP(2), .VSYNC(2), .VBP(3)
  ) dut_small (
    .Clk(Clk), .Reset_n(Reset_n), .swap_req(swap_req), .read_data(s_rd),
    .ReadX(s_rx), .ReadY(s_ry), .read_buf(s_rb), .swap_ack(s_ack), .frame_start(s_fs),
    .VGA_CLK(s_clk), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn)
  );

  function automatic int ht(geom_t g);
    return g.hv + g.hfp + g.hs + g.hbp;
  endfunction
  function automatic int nf(geom_t g);
    return ht(g) * (g.vv + g.vfp + g.vs + g.vbp);
  endfunction
  function automatic int pix(geom_t g, int k);
    return ((k % nf(g)) + nf(g)) % nf(g);
  endfunction
  function automatic bit vis(geom_t g, int p);
    return (p % ht(g)) < g.hv && (p / ht(g)) < g.vv;
  endfunction
  // After cc Clk edges, cc/2 ticks are done: the address of the last tick's pixel is
  // on ReadX/ReadY and the pixel one tick older is on the pins.
  function automatic logic [48:0] exp_vec(geom_t g, int cc, logic [23:0] fg, logic [23:0] bg);
    int k, p1, p2, x2, y2;
    logic [9:0] rx, ry;
    logic [23:0] rgb;
    logic hsn, vsn, fs;
    k   = cc / 2;
    p1  = pix(g, k - 1);
    p2  = pix(g, k - 2);
    rx  = vis(g, p1) ? 10'(p1 % ht(g)) : 10'd0;
    ry  = vis(g, p1) ? 10'(p1 / ht(g)) : 10'd0;
    x2  = p2 % ht(g);
    y2  = p2 / ht(g);
    rgb = vis(g, p2) ? (fb[y2][x2] ? fg : bg) : 24'd0;
    hsn = !(x2 >= g.hv + g.hfp && x2 < g.hv + g.hfp + g.hs);
    vsn = !(y2 >= g.vv + g.vfp && y2 < g.vv + g.vfp + g.vs);
    fs  = cc >= 2 && cc % 2 == 0 && p1 == 0;
    return {rx, ry, rgb, hsn, vsn, vis(g, p2), fs, cc[0]};
  endfunction
  function automatic bit vb_at(int n);
    return n % 2 == 0 && pix(GS, n / 2 - 1) == SVB;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      c      <= 0;
      m_pend <= 1'b0;
      m_rb   <= 1'b0;
      m_ack  <= 1'b0;
    end else begin
      c      <= c + 1;
      m_ack  <= vb_at(c + 1) && (m_pend || swap_req);
      m_rb   <= m_rb ^ (vb_at(c + 1) && (m_pend || swap_req));
      m_pend <= !vb_at(c + 1) && (m_pend || swap_req);
    end
  end

  task automatic fill_fb(input int mode);
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 640; x++)
        fb[y][x] = (mode == 0) ? x[0] : 1'($urandom);
  endtask

  task automatic do_reset;
    Reset_n  = 1'b0;
    swap_req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({f_obs, f_rb, f_ack, f_sn} !== {20'd0, 24'd0, 5'b11000, 3'b000}) begin
      errors++;
      $display("FAIL reset_full: got %h %b%b%b want %h 000", f_obs, f_rb, f_ack, f_sn, {20'd0, 24'd0, 5'b11000});
    end
    vectors++;
    if ({s_obs, s_rb, s_ack, s_sn} !== {20'd0, 24'd0, 5'b11000, 3'b000}) begin
      errors++;
      $display("FAIL reset_small: got %h %b%b%b want %h 000", s_obs, s_rb, s_ack, s_sn, {20'd0, 24'd0, 5'b11000});
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    vectors++;
    if ({s_clk, s_fs, f_clk, f_fs} !== 4'b1010) begin
      errors++;
      $display("FAIL first_edge: got clk/fs %b%b %b%b want 10 10", s_clk, s_fs, f_clk, f_fs);
    end
    @(negedge Clk);
    vectors++;
    if ({s_fs, s_rx, s_ry, f_fs, f_rx, f_ry} !== {1'b1, 20'd0, 1'b1, 20'd0}) begin
      errors++;
      $display("FAIL first_tick: got fs %b %b rx/ry %0d/%0d %0d/%0d want fs 1 1 at 0/0", s_fs, f_fs, s_rx, s_ry, f_rx, f_ry);
    end
    @(negedge Clk);
    vectors++;
    if ({s_fs, f_fs} !== 2'b00) begin
      errors++;
      $display("FAIL fs_width: got %b%b want 00", s_fs, f_fs);
    end
  endtask

  task automatic test_full_lines;
    int fall = -1, rise = -1;
    logic prev = 1'b1;
    do_reset();
    repeat (3300) begin
      @(negedge Clk);
      vectors++;
      if ({f_obs, f_rb, f_ack, f_sn} !== {exp_vec(GF, c, 24'hFFFFFF, 24'h0), 3'b000}) begin
        errors++;
        $display("FAIL full_raster c=%0d: got %h %b%b%b want %h 000", c, f_obs, f_rb, f_ack, f_sn, exp_vec(GF, c, 24'hFFFFFF, 24'h0));
      end
      if (prev && !f_hs && fall < 0) fall = c;
      if (!prev && f_hs && rise < 0 && fall >= 0) rise = c;
      prev = f_hs;
    end
    vectors++;
    if (fall != 1316) begin
      errors++;
      $display("FAIL hs_fall: got clk %0d want 1316 (pixel 656)", fall);
    end
    vectors++;
    if (rise - fall != 192) begin
      errors++;
      $display("FAIL hs_width: got %0d clk want 192", rise - fall);
    end
  endtask

  task automatic test_frame(input int mode);
    int blanks = 0, fs1 = -1, fs2 = -1;
    fill_fb(mode);
    do_reset();
    repeat (2 * 2 * SFR + 10) begin
      @(negedge Clk);
      vectors++;
      if ({s_obs, s_rb, s_ack, s_sn} !== {exp_vec(GS, c, SFG, SBG), m_rb, m_ack, 1'b0}) begin
        errors++;
        $display("FAIL frame%0d c=%0d: got %h %b%b%b want %h %b%b0", mode, c, s_obs, s_rb, s_ack, s_sn, exp_vec(GS, c, SFG, SBG), m_rb, m_ack);
      end
      if (c % 2 == 0 && c >= 2 && c <= 2 * SFR && s_bn) blanks++;
      if (s_fs && fs1 < 0) fs1 = c;
      else if (s_fs && fs2 < 0) fs2 = c;
      if (mode == 0 && (c == 4 || c == 6)) begin
        vectors++;
        if ({s_r, s_g, s_b} !== (c == 4 ? SBG : SFG)) begin
          errors++;
          $display("FAIL pattern_x%0d: got %h want %h", c / 2 - 2, {s_r, s_g, s_b}, (c == 4 ? SBG : SFG));
        end
      end
    end
    vectors++;
    if (blanks != 16 * 12) begin
      errors++;
      $display("FAIL blank_count: got %0d want 192", blanks);
    end
    vectors++;
    if (fs2 - fs1 != 2 * SFR) begin
      errors++;
      $display("FAIL fs_period: got %0d want %0d", fs2 - fs1, 2 * SFR);
    end
  endtask

  task automatic test_swap_single;
    int acks = 0, ack_c = -1;
    do_reset();
    repeat (2 * (3 * 25 + 5)) @(negedge Clk);
    swap_req = 1'b1;
    @(negedge Clk);
    swap_req = 1'b0;
    repeat (1200) begin
      @(negedge Clk);
      vectors++;
      if ({s_rb, s_ack} !== {m_rb, m_ack}) begin
        errors++;
        $display("FAIL swap_single c=%0d: got rb/ack %b%b want %b%b", c, s_rb, s_ack, m_rb, m_ack);
      end
      if (s_ack) begin
        acks++;
        if (ack_c < 0) ack_c = c;
      end
    end
    vectors++;
    if (ack_c != 602 || acks != 1 || s_rb !== 1'b1) begin
      errors++;
      $display("FAIL swap_single_sum: got ack at %0d count %0d rb %b want 602 1 1", ack_c, acks, s_rb);
    end
  endtask

  task automatic test_swap_held;
    int acks = 0;
    do_reset();
    swap_req = 1'b1;
    repeat (3 * 2 * SFR) begin
      @(negedge Clk);
      vectors++;
      if ({s_rb, s_ack} !== {m_rb, m_ack}) begin
        errors++;
        $display("FAIL swap_held c=%0d: got rb/ack %b%b want %b%b", c, s_rb, s_ack, m_rb, m_ack);
      end
      if (s_ack) acks++;
    end
    swap_req = 1'b0;
    vectors++;
    if (acks != 3 || s_rb !== 1'b1) begin
      errors++;
      $display("FAIL swap_held_sum: got %0d acks rb %b want 3 acks rb 1", acks, s_rb);
    end
  endtask

  task automatic test_swap_coincident;
    int acks = 0;
    do_reset();
    repeat (601) @(negedge Clk);
    swap_req = 1'b1;
    @(negedge Clk);
    vectors++;
    if ({s_rb, s_ack} !== 2'b11) begin
      errors++;
      $display("FAIL swap_coinc: got rb/ack %b%b want 11", s_rb, s_ack);
    end
    swap_req = 1'b0;
    repeat (1000) begin
      @(negedge Clk);
      if (s_ack) acks++;
    end
    vectors++;
    if (acks != 0 || s_rb !== 1'b1) begin
      errors++;
      $display("FAIL swap_coinc_after: got %0d acks rb %b want 0 acks rb 1", acks, s_rb);
    end
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    do_reset();
    repeat (400) @(negedge Clk);
    swap_req = 1'b1;
    @(negedge Clk);
    swap_req = 1'b0;
    repeat (21) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    vectors++;
    if ({s_obs, s_rb, s_ack} !== {20'd0, 24'd0, 5'b11000, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: got %h %b%b want %h 00", s_obs, s_rb, s_ack, {20'd0, 24'd0, 5'b11000});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (1000) begin
      @(negedge Clk);
      if (s_ack || s_rb) acks++;
      if (c == 2) begin
        vectors++;
        if ({s_fs, s_rx, s_ry} !== 21'h100000) begin
          errors++;
          $display("FAIL reset_mid_restart: got fs %b at %0d/%0d want 1 at 0/0", s_fs, s_rx, s_ry);
        end
      end
    end
    vectors++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_mid_swap: got %0d cycles with ack/rb set want 0", acks);
    end
  endtask

  initial begin
    fill_fb(0);
    test_reset();
    test_full_lines();
    test_frame(0);
    test_frame(1);
    test_swap_single();
    test_swap_held();
    test_swap_coincident();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Display-side reader of the 1-bit framebuffer, the counterpart of the renderer's draw/clear writer. It generates 640x480@60 VGA timing from the 50 MHz system clock and issues ReadX/ReadY addresses into the framebuffer. It maps returned read_data bits to RGB on the VGA pins. It also owns the double-buffer swap: a swap requested by the renderer after draw_done takes effect only at the start of vertical blanking, so no frame is torn.

## Interface
Parameters:
- FG_COLOR, 24'hFFFFFF: RGB for read_data = 1
- BG_COLOR, 24'h000000: RGB for read_data = 0 and during blanking

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  reset, asynchronous assert, active-low
- swap_req  in  1  renderer requests buffer swap (pulse; held = one request per frame)
- read_data  in  1  framebuffer bit for the last issued ReadX/ReadY
- ReadX  out  10  framebuffer read column, 0..639
- ReadY  out  10  framebuffer read row, 0..479
- read_buf  out  1  buffer index being displayed; renderer draws into ~read_buf
- swap_ack  out  1  one-Clk pulse when the swap takes effect
- frame_start  out  1  one-Clk pulse at pixel (0,0) of each frame
- VGA_CLK  out  1  25 MHz pixel clock (Clk/2)
- VGA_R, VGA_G, VGA_B  out  8 each  colour
- VGA_HS, VGA_VS  out  1  syncs, active-low
- VGA_BLANK_N  out  1  low outside the 640x480 visible area
- VGA_SYNC_N  out  1  tied 0

## Operation
- pix_en toggles every Clk and drives VGA_CLK; all timing state advances only on Clk edges where pix_en = 1 (a "tick").
- hc counts 0..799 and wraps. vc increments when hc wraps, counts 0..524, and wraps.
- Horizontal: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- ReadX = hc and ReadY = vc when visible. Outside visible, both hold 0 and no read is implied.
- Stage 2 registers, on the tick after the address was issued:
  - visible: RGB = read_data ? FG_COLOR : BG_COLOR
  - not visible: RGB = 0
  - HS, VS and BLANK_N are delayed by the same stage so they stay aligned with the colour.
- Swap FSM, states IDLE and PENDING:
  - IDLE -> PENDING when swap_req = 1.
  - PENDING -> IDLE on the vblank-start tick (hc = 0, vc = 480): read_buf toggles and swap_ack pulses in the same Clk cycle.
  - If swap_req and the vblank-start tick coincide in IDLE, the swap happens on that tick.
  - swap_req while PENDING is absorbed, giving at most one toggle per frame.
- frame_start pulses on the tick where hc = 0 and vc = 0.

## Timing
- Reset values:
  - hc, vc, pix_en, VGA_CLK = 0
  - ReadX, ReadY = 0
  - VGA_R/G/B = 0
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0
  - read_buf = 0, swap_ack = 0, frame_start = 0, FSM = IDLE
- Reset asserted mid-frame or mid-swap returns all state to the reset values immediately. The first tick after release is pixel (0,0).
- Read latency contract: read_data must be valid within 2 Clk cycles of a ReadX/ReadY change, i.e. before the next tick.
- Pipeline: pixel (x,y) appears on the VGA pins 1 tick (2 Clk) after its address is issued.
- Frame period: 800 x 525 ticks = 840000 Clk.
- HS low for 96 ticks per line. VS low for 2 lines (1600 ticks).
- swap_ack and frame_start are each exactly 1 Clk wide.

## Structure
- Shared renderer package holds:
  - the H/V visible, porch and sync constants and the totals (800/525)
  - the swap state enum
- Sub-module vga_timing holds pix_en, hc/vc, the visible/hsync/vsync decodes, and the vblank_start and frame_start strobes.
- Top level holds read addressing, the colour/delay stage and the swap FSM.

## Test plan
- Reset -> outputs hold reset values while Reset_n is low. After release, ReadX = ReadY = 0 and frame_start pulses on the first tick.
- Free-run one frame -> HS falls at hc = 656 and rises at 752. VS low for vc = 490..491. BLANK_N high for exactly 640x480 ticks. frame_start period = 840000 Clk.
- Framebuffer model returning read_data = ReadX[0] -> visible RGB alternates FFFFFF/000000 starting at 000000 at x = 0. RGB = 0 during blanking. Data is aligned 2 Clk after address.
- swap_req pulse at vc = 100 -> read_buf stays 0 until the tick with hc = 0, vc = 480, then becomes 1, with a single swap_ack pulse on that cycle.
- swap_req held high for 3 frames -> exactly 3 toggles and 3 swap_ack pulses, one per vblank. Pulse coincident with the vblank-start tick -> swap occurs on that tick.
- Reset_n low at hc = 300, vc = 200 while PENDING -> read_buf = 0, FSM = IDLE, no swap_ack. Timing restarts at (0,0).
